// File: rtl/traffic_light_monitor.sv
// Passive checker for the four-way signal-head bus: decodes n/s/e/w light
// codes into a phase, checks phase order N,N_Y,S,S_Y,E,E_Y,W,W_Y and that every
// phase lasts exactly PHASE_LEN cycles. All outputs registered (1-cycle latency).
// No backpressure: purely observes its inputs every clock.
//
// Ports:
//   clk, rst (async active-low)      clock / reset
//   n/s/e/w_lights[1:0]              head codes: 10 green, 01 yellow, 00 red, 11 illegal
//   clr_err                          synchronous clear of err_status (a new error wins)
//   phase[2:0], phase_valid          last legal decoded phase; high while LOCKED
//   err_pattern/err_order/err_timing one-cycle error pulses
//   err_status[2:0]                  sticky {timing, order, pattern}
//   rounds[RND_W-1:0]                completed correctly timed rounds (wraps)
//   dwell[DWELL_W-1:0]               cycles the current phase has been observed
module traffic_light_monitor #(
  parameter int PHASE_LEN = 8,
  parameter int DWELL_W   = 4,
  parameter int RND_W     = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         n_lights,
  input  logic [1:0]         s_lights,
  input  logic [1:0]         e_lights,
  input  logic [1:0]         w_lights,
  input  logic               clr_err,
  output logic [2:0]         phase,
  output logic               phase_valid,
  output logic               err_pattern,
  output logic               err_order,
  output logic               err_timing,
  output logic [2:0]         err_status,
  output logic [RND_W-1:0]   rounds,
  output logic [DWELL_W-1:0] dwell
);

  localparam logic [DWELL_W-1:0] LEN    = DWELL_W'(PHASE_LEN);
  localparam logic [DWELL_W-1:0] LEN_P1 = DWELL_W'(PHASE_LEN + 1);

  typedef enum logic {ACQUIRE = 1'b0, LOCKED = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [2:0]         phase_q, phase_d;     // doubles as the previous-phase register
  logic               prev_legal_q, prev_legal_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [RND_W-1:0]   rounds_q, rounds_d;
  logic [2:0]         err_status_q, err_status_d;
  logic               pat_q, pat_d, ord_q, ord_d, tim_q, tim_d;

  logic [3:0] non_red;
  logic       any_11;
  logic       dec_legal;
  logic [2:0] dec_phase;
  logic [2:0] next_phase;

  // Decode: legal only when exactly one head is non-red and no head shows 11.
  always_comb begin
    non_red   = {w_lights != 2'b00, e_lights != 2'b00, s_lights != 2'b00, n_lights != 2'b00};
    any_11    = (n_lights == 2'b11) || (s_lights == 2'b11) ||
                (e_lights == 2'b11) || (w_lights == 2'b11);
    dec_legal = 1'b0;
    dec_phase = 3'd0;
    case (non_red)
      4'b0001: begin dec_legal = 1'b1; dec_phase = {2'd0, n_lights == 2'b01}; end
      4'b0010: begin dec_legal = 1'b1; dec_phase = {2'd1, s_lights == 2'b01}; end
      4'b0100: begin dec_legal = 1'b1; dec_phase = {2'd2, e_lights == 2'b01}; end
      4'b1000: begin dec_legal = 1'b1; dec_phase = {2'd3, w_lights == 2'b01}; end
      default: begin dec_legal = 1'b0; dec_phase = 3'd0; end
    endcase
    if (any_11) dec_legal = 1'b0;
  end

  assign next_phase = phase_q + 3'd1;

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    prev_legal_d = prev_legal_q;
    dwell_d      = dwell_q;
    rounds_d     = rounds_q;
    pat_d        = 1'b0;
    ord_d        = 1'b0;
    tim_d        = 1'b0;

    if (!dec_legal) begin
      pat_d        = 1'b1;
      state_d      = ACQUIRE;
      dwell_d      = '0;
      prev_legal_d = 1'b0;
    end else begin
      phase_d      = dec_phase;
      prev_legal_d = 1'b1;
      if (!prev_legal_q) begin
        // First legal sample after reset or a bad pattern: nothing to compare against.
        dwell_d = DWELL_W'(1);
      end else if (dec_phase == phase_q) begin
        if (state_q == LOCKED && dwell_q == LEN) begin
          // This sample would be cycle PHASE_LEN+1 of the phase.
          tim_d   = 1'b1;
          state_d = ACQUIRE;
          dwell_d = LEN_P1;
        end else if (dwell_q != '1) begin
          dwell_d = dwell_q + DWELL_W'(1);
        end
      end else begin
        dwell_d = DWELL_W'(1);
        if (state_q == ACQUIRE) begin
          if (dec_phase == next_phase) state_d = LOCKED;
        end else if (dec_phase != next_phase) begin
          // Order error masks a simultaneous timing error.
          ord_d   = 1'b1;
          state_d = ACQUIRE;
        end else if (dwell_q != LEN) begin
          tim_d   = 1'b1;
          state_d = ACQUIRE;
        end else if (phase_q == 3'd7) begin
          rounds_d = rounds_q + RND_W'(1);
        end
      end
    end

    // A new error on the same cycle as clr_err still latches.
    err_status_d = (clr_err ? 3'b000 : err_status_q) | {tim_d, ord_d, pat_d};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ACQUIRE;
      phase_q      <= 3'd0;
      prev_legal_q <= 1'b0;
      dwell_q      <= '0;
      rounds_q     <= '0;
      err_status_q <= 3'b000;
      pat_q        <= 1'b0;
      ord_q        <= 1'b0;
      tim_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      prev_legal_q <= prev_legal_d;
      dwell_q      <= dwell_d;
      rounds_q     <= rounds_d;
      err_status_q <= err_status_d;
      pat_q        <= pat_d;
      ord_q        <= ord_d;
      tim_q        <= tim_d;
    end
  end

  assign phase       = phase_q;
  assign phase_valid = (state_q == LOCKED);
  assign err_pattern = pat_q;
  assign err_order   = ord_q;
  assign err_timing  = tim_q;
  assign err_status  = err_status_q;
  assign rounds      = rounds_q;
  assign dwell       = dwell_q;

endmodule

// File: doc/traffic_light_monitor.md
Name: traffic_light_monitor

Overview:
Passive checker on the receive side of the four-way signal-head bus. It decodes the n/s/e/w 2-bit light codes driven by the four-way controller back into a phase number. It verifies the phase order N, N_Y, S, S_Y, E, E_Y, W, W_Y and checks that every phase lasts exactly PHASE_LEN cycles. Errors are reported as one-cycle pulses and sticky status bits for the safety/diagnostic logic.

Parameters:
PHASE_LEN, 8, required dwell of every phase in clk cycles (legal range 2 to 2**DWELL_W-2)
DWELL_W, 4, width of dwell counter
RND_W, 8, width of completed-round counter

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  asynchronous, active-low reset
n_lights  input  2  north head code: 10 green, 01 yellow, 00 red, 11 illegal
s_lights  input  2  south head code, same encoding
e_lights  input  2  east head code, same encoding
w_lights  input  2  west head code, same encoding
clr_err  input  1  synchronous clear of err_status
phase  output  3  last legal decoded phase: 0 N, 1 N_Y, 2 S, 3 S_Y, 4 E, 5 E_Y, 6 W, 7 W_Y
phase_valid  output  1  high while in LOCKED
err_pattern  output  1  one-cycle pulse on an illegal light pattern
err_order  output  1  one-cycle pulse on an out-of-order phase change
err_timing  output  1  one-cycle pulse on a dwell violation
err_status  output  3  sticky errors: bit0 pattern, bit1 order, bit2 timing
rounds  output  RND_W  count of complete correctly timed rounds, wraps
dwell  output  DWELL_W  cycles the current phase has been observed

Behaviour:
- Reset (rst low, asynchronous): state ACQUIRE; phase, dwell, rounds, err_status = 0; all pulses and phase_valid = 0; prev_phase register = 0; prev_legal = 0.
- Decode (combinational on inputs):
  - Legal pattern: exactly one head non-red, and that head is 10 or 01. Phase = 2*head_index + (code==01), with head_index N=0, S=1, E=2, W=3.
  - Illegal pattern: all red, any code 11, or more than one non-red head.
- Registered outputs: all outputs are registered. A flag caused by the sample taken at edge k is high for exactly the cycle following edge k.
- next(P) = (P+1) mod 8.
- ACQUIRE state:
  - Illegal sample: pulse err_pattern, set err_status[0], dwell = 0, prev_legal = 0.
  - Legal sample equal to prev_phase with prev_legal = 1: dwell increments, saturating at all-ones.
  - Legal sample Q different from prev_phase P with prev_legal = 1:
    - If Q == next(P): go to LOCKED, dwell = 1.
    - Otherwise: stay in ACQUIRE, dwell = 1.
  - No order or timing checks are made in ACQUIRE.
  - prev_phase and phase update on every legal sample; prev_legal = 1.
- LOCKED state (phase_valid = 1):
  - Same phase, dwell < PHASE_LEN: dwell increments.
  - Same phase, dwell == PHASE_LEN (the sample would be cycle PHASE_LEN+1): pulse err_timing, set err_status[2], go to ACQUIRE, dwell = PHASE_LEN+1.
  - Phase change P to Q: dwell = 1.
    - If Q != next(P): pulse err_order, set bit1, go to ACQUIRE.
    - Else if dwell != PHASE_LEN: pulse err_timing, set bit2, go to ACQUIRE.
    - Else: stay in LOCKED. If P == 7 and Q == 0, rounds increments (wraps).
  - If both the order and timing checks fail on the same change, only err_order is reported.
  - Illegal sample: pulse err_pattern, set bit0, go to ACQUIRE, dwell = 0, prev_legal = 0.
- err_status: bits stay set until clr_err. On a cycle where clr_err and a new error occur together, the new error's bit is set and the other bits clear (set wins).
- Reset mid-operation: all state and outputs return immediately to reset values. There is no pulse on reset deassertion.

Test Plan:
- Nominal: after reset, drive the legal sequence with 8 cycles per phase for 3 rounds, then 1 cycle of N -> LOCKED one cycle after the first N to N_Y edge; phase_valid stays 1; no error pulses; rounds = 3; dwell cycles 1 to 8 each phase.
- Conflict: while LOCKED in S, drive n=10 and s=10 for one cycle -> err_pattern pulse for 1 cycle, err_status = 001, phase_valid = 0; relock on the next legal in-order change.
- Order: while LOCKED, N_Y for 8 cycles followed by E -> err_order pulse, err_status[1] = 1, err_timing stays 0, state ACQUIRE.
- Timing short and long:
  - N green for 5 cycles, then N_Y -> err_timing at the change.
  - Separately, E green held for 9 cycles -> err_timing after the 9th sample; dwell = 9.
- Clear collision: with err_status = 011, assert clr_err in the same cycle as a timing violation -> err_status = 100 next cycle.
- Reset mid-round: pull rst low during LOCKED W -> all outputs 0 asynchronously; after release, no errors until the first legal phase change.
